swg_write_controller: RTL and testbench

- Write-side (ingest) controller for the sliding-window generator's cyclic buffer.
- Accepts the input feature-map AXI-stream and drives the buffer write port with a wrapping address.
- Tracks buffer occupancy, releasing space as the read-side loop controller reports tail increments.
- Exposes an available-element count to the read side and handles image boundaries with a fill/drain state machine.

---
 rtl/swg_pkg.sv | 11 +
 rtl/swg_write_controller_if.sv | 29 ++
 rtl/swg_wrap_counter.sv | 34 +++
 rtl/swg_write_controller.sv | 103 ++++++++++
 tb/tb_swg_write_controller.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/swg_pkg.sv
// Shared types and width helpers for the sliding-window generator write side.
package swg_pkg;

    typedef enum logic [0:0] {STATE_FILL, STATE_DRAIN} swg_wr_state_e;

    // Bit width needed to index n items; never less than 1 so degenerate sizes still elaborate.
    function automatic int clog2_depth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/swg_write_controller_if.sv
// Input feature-map stream plus the cyclic buffer write port, grouped for the write controller.
interface swg_write_controller_if
    import swg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 16
);
    localparam int AW = clog2_depth(BUF_DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             buf_we;
    logic [AW-1:0]    buf_waddr;
    logic [WIDTH-1:0] buf_wdata;

    // Environment side: produces the stream, consumes the buffer write port.
    modport master (
        output in_valid, in_data,
        input  in_ready, buf_we, buf_waddr, buf_wdata
    );

    // Controller side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, buf_we, buf_waddr, buf_wdata
    );

endinterface

// File: rtl/swg_wrap_counter.sv
// Modulo-MAX up counter: advances on en, wraps MAX-1 to 0, count valid the cycle after en.
module swg_wrap_counter
    import swg_pkg::*;
#(
    parameter int MAX = 16,
    localparam int W  = clog2_depth(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == W'(MAX - 1)) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/swg_write_controller.sv
// Ingest side of the sliding-window cyclic buffer: zero-latency write on handshake, occupancy tracking.
// in_ready is registered-only; it drops when the buffer is full or the image is waiting to drain.
module swg_write_controller
    import swg_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int BUF_DEPTH     = 16,
    parameter int IMG_ELEMS     = 64,
    parameter int INCR_BITWIDTH = 8,
    localparam int CW           = $clog2(BUF_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    swg_write_controller_if.slave    bus,
    input  logic                     tail_advance,
    input  logic [INCR_BITWIDTH-1:0] tail_incr,
    input  logic                     read_last,
    output logic [CW-1:0]            avail,
    output logic                     overflow_err
);

    localparam int AW = clog2_depth(BUF_DEPTH);
    localparam int EW = clog2_depth(IMG_ELEMS);
    localparam int SW = CW + INCR_BITWIDTH + 1;

    swg_wr_state_e state_q, state_d;
    logic [CW-1:0] fill_q, fill_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] addr_q;
    logic [EW-1:0] elem_q;
    logic          fire;
    logic          in_ready;
    logic [SW-1:0] fill_net;

    swg_wrap_counter #(.MAX(BUF_DEPTH)) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fire),
        .count (addr_q)
    );

    swg_wrap_counter #(.MAX(IMG_ELEMS)) u_elem_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fire),
        .count (elem_q)
    );

    assign in_ready = (state_q == STATE_FILL) && (fill_q < CW'(BUF_DEPTH));
    assign fire     = bus.in_valid & in_ready;

    always_comb begin
        // Net occupancy in a wider two's-complement space; the MSB flags an over-free.
        fill_net = SW'(fill_q) + SW'(fire) - (tail_advance ? SW'(tail_incr) : SW'(0));
        state_d  = state_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;
        if (fill_net[SW-1]) begin
            fill_d = '0;
            ovf_d  = 1'b1;
        end else begin
            fill_d = fill_net[CW-1:0];
        end
        case (state_q)
            STATE_FILL: begin
                if (fire && (elem_q == EW'(IMG_ELEMS - 1))) begin
                    state_d = STATE_DRAIN;
                end
            end
            STATE_DRAIN: begin
                // End of image discards any same-cycle free, including its overflow check.
                if (read_last) begin
                    state_d = STATE_FILL;
                    fill_d  = '0;
                    ovf_d   = ovf_q;
                end
            end
            default: state_d = STATE_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STATE_FILL;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.buf_we    = fire;
    assign bus.buf_waddr = addr_q;
    assign bus.buf_wdata = bus.in_data;
    assign avail         = fill_q;
    assign overflow_err  = ovf_q;

    fill_bounded_a: assert property (@(posedge clk) disable iff (!rst_n) fill_q <= CW'(BUF_DEPTH));

endmodule

// File: tb/tb_swg_write_controller.sv
// Directed bench for swg_write_controller with BUF_DEPTH=6, IMG_ELEMS=9.
module tb_swg_write_controller;
    import swg_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 6;
    localparam int IMG   = 9;
    localparam int IW    = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tail_advance;
    logic [IW-1:0] tail_incr;
    logic          read_last;
    logic [CW-1:0] avail;
    logic          overflow_err;
    int            errors = 0;
    int            checks = 0;

    swg_write_controller_if #(.WIDTH(WIDTH), .BUF_DEPTH(DEPTH)) bus ();

    swg_write_controller #(
        .WIDTH(WIDTH), .BUF_DEPTH(DEPTH), .IMG_ELEMS(IMG), .INCR_BITWIDTH(IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .tail_advance (tail_advance),
        .tail_incr    (tail_incr),
        .read_last    (read_last),
        .avail        (avail),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic ta,
                          input logic [IW-1:0] ti, input logic rl);
        bus.in_valid = v;
        bus.in_data  = d;
        tail_advance = ta;
        tail_incr    = ti;
        read_last    = rl;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 8'h00, 1'b0, '0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_avail", 32'(avail), 0);
        check("rst_waddr", 32'(bus.buf_waddr), 0);
        check("rst_ready", 32'(bus.in_ready), 1);
        check("rst_ovf", 32'(overflow_err), 0);
        check("rst_we_idle", 32'(bus.buf_we), 0);

        // Six back-to-back beats fill the buffer.
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 8'(8'h10 + i), 1'b0, '0, 1'b0);
            check($sformatf("fill_we%0d", i), 32'(bus.buf_we), 1);
            check($sformatf("fill_waddr%0d", i), 32'(bus.buf_waddr), 32'(i));
            check($sformatf("fill_wdata%0d", i), 32'(bus.buf_wdata), 32'(8'h10 + i));
            tick();
        end
        check("full_ready", 32'(bus.in_ready), 0);
        check("full_we", 32'(bus.buf_we), 0);
        check("full_avail", 32'(avail), 6);

        // Free 2 while full; ready returns next cycle and the next write wraps to 0.
        set_in(1'b1, 8'h16, 1'b1, 4'd2, 1'b0);
        check("free_ready_same_cycle", 32'(bus.in_ready), 0);
        tick();
        set_in(1'b1, 8'h16, 1'b0, '0, 1'b0);
        check("free_avail", 32'(avail), 4);
        check("free_ready", 32'(bus.in_ready), 1);
        check("wrap_we", 32'(bus.buf_we), 1);
        check("wrap_waddr", 32'(bus.buf_waddr), 0);
        tick();
        check("wrap_avail", 32'(avail), 5);

        // Bring occupancy to 3, then write and free one in the same cycle.
        set_in(1'b0, 8'h00, 1'b1, 4'd2, 1'b0);
        tick();
        check("avail3", 32'(avail), 3);
        set_in(1'b1, 8'h17, 1'b1, 4'd1, 1'b0);
        check("sim_we", 32'(bus.buf_we), 1);
        check("sim_waddr", 32'(bus.buf_waddr), 1);
        tick();
        set_in(1'b0, 8'h00, 1'b0, '0, 1'b0);
        check("sim_avail", 32'(avail), 3);
        check("sim_waddr_next", 32'(bus.buf_waddr), 2);

        // Ninth beat of the image moves to DRAIN.
        set_in(1'b1, 8'h18, 1'b0, '0, 1'b0);
        check("last_we", 32'(bus.buf_we), 1);
        check("last_waddr", 32'(bus.buf_waddr), 2);
        tick();
        check("drain_ready", 32'(bus.in_ready), 0);
        check("drain_we", 32'(bus.buf_we), 0);
        check("drain_avail", 32'(avail), 4);
        tick();
        check("drain_hold_ready", 32'(bus.in_ready), 0);
        set_in(1'b1, 8'h20, 1'b1, 4'd3, 1'b1);
        tick();
        set_in(1'b1, 8'h20, 1'b0, '0, 1'b0);
        check("rlast_avail", 32'(avail), 0);
        check("rlast_ready", 32'(bus.in_ready), 1);
        check("rlast_ovf", 32'(overflow_err), 0);
        check("img2_waddr", 32'(bus.buf_waddr), 3);
        check("img2_we", 32'(bus.buf_we), 1);
        tick();
        set_in(1'b1, 8'h21, 1'b0, '0, 1'b0);
        check("img2_waddr1", 32'(bus.buf_waddr), 4);
        tick();
        set_in(1'b0, 8'h00, 1'b0, '0, 1'b0);
        check("img2_avail", 32'(avail), 2);

        // read_last outside DRAIN is ignored.
        set_in(1'b0, 8'h00, 1'b0, '0, 1'b1);
        tick();
        set_in(1'b0, 8'h00, 1'b0, '0, 1'b0);
        check("fill_rlast_avail", 32'(avail), 2);
        check("fill_rlast_ready", 32'(bus.in_ready), 1);
        check("fill_rlast_ovf", 32'(overflow_err), 0);

        // Over-free clamps to zero and sets the sticky error.
        set_in(1'b0, 8'h00, 1'b1, 4'd5, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, '0, 1'b0);
        check("ovf_avail", 32'(avail), 0);
        check("ovf_set", 32'(overflow_err), 1);
        tick();
        tick();
        check("ovf_sticky", 32'(overflow_err), 1);

        // Two more beats, then reset mid-image.
        set_in(1'b1, 8'h22, 1'b0, '0, 1'b0);
        check("pre_rst_waddr5", 32'(bus.buf_waddr), 5);
        tick();
        set_in(1'b1, 8'h23, 1'b0, '0, 1'b0);
        check("pre_rst_waddr0", 32'(bus.buf_waddr), 0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, '0, 1'b0);
        check("pre_rst_avail", 32'(avail), 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_waddr", 32'(bus.buf_waddr), 0);
        check("mid_rst_avail", 32'(avail), 0);
        check("mid_rst_ready", 32'(bus.in_ready), 1);
        check("mid_rst_ovf", 32'(overflow_err), 0);

        // A fresh full image with a steady one-element free per beat.
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 8'(8'h30 + i), (i != 0), (i != 0) ? 4'd1 : 4'd0, 1'b0);
            check($sformatf("img3_we%0d", i), 32'(bus.buf_we), 1);
            check($sformatf("img3_waddr%0d", i), 32'(bus.buf_waddr), 32'(i % 6));
            tick();
        end
        set_in(1'b1, 8'h40, 1'b0, '0, 1'b0);
        check("img3_drain_ready", 32'(bus.in_ready), 0);
        check("img3_avail", 32'(avail), 1);
        set_in(1'b0, 8'h00, 1'b0, '0, 1'b1);
        tick();
        set_in(1'b0, 8'h00, 1'b0, '0, 1'b0);
        check("img3_rlast_avail", 32'(avail), 0);
        check("img3_rlast_ready", 32'(bus.in_ready), 1);
        check("img3_waddr", 32'(bus.buf_waddr), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
